// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and helpers for the fetch/data SRAM arbiter
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Counter width for a saturating streak of 0..max; never narrower than one bit.
  function automatic int streak_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_streak_ctr.sv
// rtl/sram_arbiter_streak_ctr.sv - saturating streak counter with clear/inc/hold
module sram_arbiter_streak_ctr
  import sram_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam int            W     = streak_w(MAX);
  localparam logic [W-1:0]  MAX_V = W'(MAX);

  logic [W-1:0] r_count;

  // Clear wins over increment; increment stops at MAX so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_V)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_max = (MAX != 0) && (r_count == MAX_V);

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port SRAM between the fetch and data ports
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int D_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  logic   w_at_max;
  logic   w_i_gnt;
  logic   w_d_gnt;
  owner_e r_owner;

  // Data wins unless fetch has been starved for D_BURST_MAX data grants in a row.
  always_comb begin
    w_d_gnt = !reset && d_req && !(w_at_max && i_req);
    w_i_gnt = !reset && i_req && !w_d_gnt;
  end

  sram_arbiter_streak_ctr #(
    .MAX      (D_BURST_MAX)
  ) u_streak (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_i_gnt || !i_req),
    .i_inc    (w_d_gnt && i_req),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else if (w_i_gnt) begin
      r_owner <= OWN_I;
    end else if (w_d_gnt && !d_we) begin
      r_owner <= OWN_D;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign m_en     = w_i_gnt || w_d_gnt;
  assign m_we     = w_d_gnt && d_we;
  assign m_addr   = w_i_gnt ? i_addr : d_addr;
  assign m_wdata  = d_wdata;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  // A reset landing on the response cycle discards that response.
  assign i_rvalid = (r_owner == OWN_I) && !reset;
  assign d_rvalid = (r_owner == OWN_D) && !reset;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter against a behavioural model
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic [31:0] b_m_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(32), .DW(32), .D_BURST_MAX(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rdata(a_i_rdata), .i_rvalid(a_i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rdata(a_d_rdata), .d_rvalid(a_d_rvalid),
    .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
  );

  sram_arbiter #(.AW(32), .DW(32), .D_BURST_MAX(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rdata(b_i_rdata), .i_rvalid(b_i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rdata(b_d_rdata), .d_rvalid(b_d_rvalid),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
  );

  // SRAM macro model for the guarded instance
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (a_m_en) begin
      if (a_m_we) mem[a_m_addr[9:2]] = a_m_wdata;
      else        a_m_rdata <= mem[a_m_addr[9:2]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  int          str4 = 0;
  int          str0 = 0;
  int          pend = 0;           // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data = 32'h0;

  logic        obs_i_gnt, obs_d_gnt, obs_b_i_gnt, obs_i_rvalid, obs_d_rvalid;
  logic [31:0] obs_d_rdata;

  function automatic logic [1:0] exp_grant(int max, int streak, logic rst, logic ir, logic dr);
    logic fetch_starved;
    fetch_starved = (max != 0) && (streak >= max) && ir;
    if (rst)                   return 2'b00;
    if (dr && !fetch_starved)  return 2'b01;
    if (ir)                    return 2'b10;
    return 2'b00;
  endfunction

  function automatic int next_streak(int streak, int max, logic [1:0] g, logic ir, logic rst);
    if (rst || g[1] || !ir) return 0;
    if (g[0])               return (streak < max) ? streak + 1 : streak;
    return streak;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle();
    logic [1:0] g4, g0;
    logic [7:0] ia, da;
    ia = i_addr[9:2];
    da = d_addr[9:2];
    g4 = exp_grant(4, str4, reset, i_req, d_req);
    g0 = exp_grant(0, str0, reset, i_req, d_req);
    #3;
    obs_i_gnt    = a_i_gnt;
    obs_d_gnt    = a_d_gnt;
    obs_b_i_gnt  = b_i_gnt;
    obs_i_rvalid = a_i_rvalid;
    obs_d_rvalid = a_d_rvalid;
    obs_d_rdata  = a_d_rdata;
    check("i_gnt",    {31'b0, a_i_gnt}, {31'b0, g4[1]});
    check("d_gnt",    {31'b0, a_d_gnt}, {31'b0, g4[0]});
    check("m_en",     {31'b0, a_m_en},  {31'b0, |g4});
    check("m_we",     {31'b0, a_m_we},  {31'b0, g4[0] & d_we});
    check("m_addr",   a_m_addr, g4[1] ? i_addr : d_addr);
    check("m_wdata",  a_m_wdata, d_wdata);
    check("i_rvalid", {31'b0, a_i_rvalid}, {31'b0, (pend == 1) && !reset});
    check("d_rvalid", {31'b0, a_d_rvalid}, {31'b0, (pend == 2) && !reset});
    if (pend == 1 && !reset) check("i_rdata", a_i_rdata, pend_data);
    if (pend == 2 && !reset) check("d_rdata", a_d_rdata, pend_data);
    check("nog_i_gnt", {31'b0, b_i_gnt}, {31'b0, g0[1]});
    check("nog_d_gnt", {31'b0, b_d_gnt}, {31'b0, g0[0]});
    @(posedge clk);
    if (reset)                  pend = 0;
    else if (g4[1])             pend = 1;
    else if (g4[0] && !d_we)    pend = 2;
    else                        pend = 0;
    pend_data = g4[1] ? ref_mem[ia] : ref_mem[da];
    if (!reset && g4[0] && d_we) ref_mem[da] = d_wdata;
    str4 = next_streak(str4, 4, g4, i_req, reset);
    str0 = next_streak(str0, 0, g0, i_req, reset);
    #1;
  endtask

  task automatic set_in(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic we, input logic [31:0] da, input logic [31:0] wd);
    reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
  endtask

  initial begin
    string pat;
    int    nog_i_cnt;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = 32'hA500_0000 ^ (k * 32'h0001_0203);
      ref_mem[k] = 32'hA500_0000 ^ (k * 32'h0001_0203);
    end
    set_in(1, 1, 32'h100, 1, 0, 32'h40, 32'h0);
    @(posedge clk); #1;

    // Reset held with both requesting, then release: data wins first
    cycle();
    cycle();
    set_in(0, 1, 32'h100, 1, 0, 32'h40, 32'h0);
    cycle();
    check("post_reset_d_gnt", {31'b0, obs_d_gnt}, 32'd1);
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle();
    check("post_reset_owner_d", {31'b0, obs_d_rvalid}, 32'd1);

    // Back-to-back fetches
    set_in(0, 1, 32'h100, 0, 0, 32'h0, 32'h0);
    cycle();
    set_in(0, 1, 32'h104, 0, 0, 32'h0, 32'h0);
    cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle();
    cycle();

    // Write then read back the same address
    set_in(0, 0, 32'h0, 1, 1, 32'h20, 32'hDEAD_BEEF);
    cycle();
    set_in(0, 0, 32'h0, 1, 0, 32'h20, 32'h0);
    cycle();
    check("write_no_rvalid", {31'b0, obs_d_rvalid}, 32'd0);
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle();
    check("raw_d_rdata", obs_d_rdata, 32'hDEAD_BEEF);

    // Both requesting for 12 cycles: guarded pattern and unguarded starvation
    pat = "";
    nog_i_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      set_in(0, 1, 32'h200 + 32'(c * 4), 1, 0, 32'h80 + 32'(c * 4), 32'h0);
      cycle();
      pat = {pat, obs_d_gnt ? "D" : (obs_i_gnt ? "I" : "-")};
      if (obs_b_i_gnt) nog_i_cnt++;
    end
    n_checks++;
    assert (pat == "DDDDIDDDDIDD") else begin
      n_errors++;
      $error("FAIL grant_pattern: observed %s expected DDDDIDDDDIDD", pat);
    end
    check("nog_i_starved", 32'(nog_i_cnt), 32'd0);
    set_in(0, 1, 32'h300, 0, 0, 32'h0, 32'h0);
    cycle();
    check("nog_i_on_drop", {31'b0, obs_b_i_gnt}, 32'd1);

    // Reset on the response cycle suppresses rvalid
    set_in(0, 1, 32'h108, 0, 0, 32'h0, 32'h0);
    cycle();
    set_in(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle();
    check("reset_kills_i_rvalid", {31'b0, obs_i_rvalid}, 32'd0);
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle();
    check("reset_owner_none", {31'b0, obs_i_rvalid | obs_d_rvalid}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 49) == 0,
             $urandom_range(0, 9) < 7, {22'b0, 8'($urandom), 2'b00},
             $urandom_range(0, 9) < 6, 1'($urandom), {22'b0, 8'($urandom_range(0, 15)), 2'b00},
             $urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
